// File: rtl/sad_argmin_accumulator.sv
// Accumulates 32 per-lane SADs over one window row, then scans them serially
// to track the global minimum (row, col, SAD) across the whole search window.
module sad_argmin_accumulator #(
  parameter int unsigned POI_DEPTH = 4,
  parameter int unsigned POI_WIDTH = 4,
  parameter logic [4:0]  LAST_ROW  = 5'd31
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0][7:0]                       residuals,
  input  logic [4:0]                             w_row_wr,
  input  logic [POI_DEPTH+POI_WIDTH-1:0]         POI_addr_wr,
  output logic                                   done,
  output logic [4:0]                             best_row,
  output logic [4:0]                             best_col,
  output logic [8+POI_DEPTH+POI_WIDTH-1:0]       best_sad
);

  localparam int unsigned ADDR_W = POI_DEPTH + POI_WIDTH;
  localparam int unsigned ACC_W  = 8 + ADDR_W;
  localparam int unsigned LANES  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCAN,
    ST_DONE
  } state_e;

  state_e             state_q,    state_d;
  logic [ACC_W-1:0]   acc_q [LANES];
  logic [ACC_W-1:0]   acc_d [LANES];
  logic [4:0]         cur_row_q,  cur_row_d;
  logic [4:0]         scan_idx_q, scan_idx_d;
  logic [4:0]         best_row_q, best_row_d;
  logic [4:0]         best_col_q, best_col_d;
  logic [ACC_W-1:0]   best_sad_q, best_sad_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cur_row_d  = cur_row_q;
    scan_idx_d = scan_idx_q;
    best_row_d = best_row_q;
    best_col_d = best_col_q;
    best_sad_d = best_sad_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ACCUM;
          best_sad_d = '1;
          best_row_d = '0;
          best_col_d = '0;
          for (int i = 0; i < LANES; i++) acc_d[i] = '0;
        end
      end

      ST_ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i] + ACC_W'(residuals[i]);
          // The last POI pixel closes the row; its beat is included above.
          if (POI_addr_wr == '1) begin
            cur_row_d  = w_row_wr;
            scan_idx_d = '0;
            state_d    = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        // Strict compare: ties keep the earlier row, then the lower column.
        if (acc_q[scan_idx_q] < best_sad_q) begin
          best_sad_d = acc_q[scan_idx_q];
          best_row_d = cur_row_q;
          best_col_d = scan_idx_q;
        end
        if (scan_idx_q == 5'd31) begin
          scan_idx_d = '0;
          for (int i = 0; i < LANES; i++) acc_d[i] = '0;
          state_d = (cur_row_q == LAST_ROW) ? ST_DONE : ST_ACCUM;
        end else begin
          scan_idx_d = scan_idx_q + 5'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_row_q  <= '0;
      scan_idx_q <= '0;
      best_row_q <= '0;
      best_col_q <= '0;
      best_sad_q <= '0;
      // NOTE: the accumulator bank is reset explicitly so an abandoned row never leaks into the next search.
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      scan_idx_q <= scan_idx_d;
      best_row_q <= best_row_d;
      best_col_q <= best_col_d;
      best_sad_q <= best_sad_d;
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign in_ready = (state_q == ST_ACCUM);
  assign done     = (state_q == ST_DONE);
  assign best_row = best_row_q;
  assign best_col = best_col_q;
  assign best_sad = best_sad_q;

endmodule

// File: tb/tb_sad_argmin_accumulator.sv
// Self-checking bench for sad_argmin_accumulator: randomized and directed rows
// compared against a plain-arithmetic SAD/argmin model.
module tb_sad_argmin_accumulator;

  localparam int LANES = 32;
  localparam int BEATS = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [31:0][7:0] residuals;
  logic [4:0]      w_row_wr;
  logic [7:0]      POI_addr_wr;
  logic            done;
  logic [4:0]      best_row;
  logic [4:0]      best_col;
  logic [15:0]     best_sad;

  sad_argmin_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .residuals   (residuals),
    .w_row_wr    (w_row_wr),
    .POI_addr_wr (POI_addr_wr),
    .done        (done),
    .best_row    (best_row),
    .best_col    (best_col),
    .best_sad    (best_sad)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: global best over rows in presentation order.
  int unsigned exp_row, exp_col, exp_sad;
  int unsigned row_sad [LANES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] residual_for(input int mode, input int row, input int lane,
                                              input int beat);
    int target;
    case (mode)
      1: return (lane == 7) ? 8'd1 : 8'd2;
      2: begin
        target = ((row == 5 && lane == 3) || (row == 12 && lane == 9)) ? 100 : 200;
        return (beat < target) ? 8'd1 : 8'd0;
      end
      3: return 8'd255;
      4: return 8'($urandom_range(0, 1));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic begin_search();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_sad = 32'h0000_FFFF;
    exp_row = 0;
    exp_col = 0;
  endtask

  task automatic drive_junk();
    in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) residuals[l] = 8'($urandom_range(0, 255));
    POI_addr_wr = 8'($urandom_range(0, 255));
    w_row_wr    = 5'($urandom_range(0, 31));
  endtask

  task automatic send_row(input int row, input int mode, input bit start_in_scan, input bit last);
    int n;
    int stalls;
    logic [7:0] r;
    for (int l = 0; l < LANES; l++) row_sad[l] = 0;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("row_ready", in_ready, 1);
    stalls = 0;
    for (int b = 0; b < BEATS; b++) begin
      in_valid    = 1'b1;
      w_row_wr    = 5'(row);
      POI_addr_wr = 8'(b);
      for (int l = 0; l < LANES; l++) begin
        r = residual_for(mode, row, l, b);
        residuals[l] = r;
        row_sad[l] += r;
      end
      if (!in_ready) stalls++;
      tick();
    end
    check("row_stall", stalls, 0);
    // Keep valid asserted with junk through the scan; none of it may be accepted.
    n = 0;
    while (!in_ready && !done && n < 40) begin
      drive_junk();
      start = start_in_scan && (n == 5);
      tick();
      n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("scan_cycles", n, 32);
    check(last ? "done_rise" : "ready_rise", {30'd0, done, in_ready}, last ? 2 : 1);
    for (int l = 0; l < LANES; l++) begin
      if (row_sad[l] < exp_sad) begin
        exp_sad = row_sad[l];
        exp_row = row;
        exp_col = l;
      end
    end
  endtask

  task automatic run_rows(input int mode, input bit shuffle, input int start_row);
    int order [$];
    int j, t;
    for (int i = 0; i < 31; i++) order.push_back(i);
    if (shuffle) begin
      for (int i = 30; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
    end
    for (int i = 0; i < 31; i++) send_row(order[i], mode, (i == start_row), 1'b0);
    send_row(31, mode, 1'b0, 1'b1);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_row"}, best_row, exp_row);
    check({tag, "_col"}, best_col, exp_col);
    check({tag, "_sad"}, best_sad, exp_sad);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    residuals = '0; w_row_wr = '0; POI_addr_wr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle with valid asserted and no start: nothing moves.
    for (int i = 0; i < 4; i++) begin
      drive_junk();
      tick();
    end
    check("idle_ready", in_ready, 0);
    check("idle_done", done, 0);
    check("idle_row", best_row, 0);
    check("idle_col", best_col, 0);
    check("idle_sad", best_sad, 0);
    in_valid = 1'b0;

    // Single row (the terminal row alone completes the search).
    begin_search();
    send_row(31, 1, 1'b0, 1'b1);
    check_result("single");
    check("single_sad_abs", best_sad, 256);
    for (int i = 0; i < 3; i++) tick();
    check("done_held", done, 1);
    check("held_sad", best_sad, 256);

    // Start from DONE drops done next cycle; tie case with a start during a scan.
    begin_search();
    check("restart_done", done, 0);
    check("restart_ready", in_ready, 1);
    run_rows(2, 1'b0, 20);
    check_result("tie");

    // Maximum accumulation, no wrap.
    begin_search();
    run_rows(3, 1'b0, -1);
    check_result("max");
    check("max_sad_abs", best_sad, 65280);

    // Reset mid-accumulation of row 10 at address 100.
    begin_search();
    for (int i = 0; i < 10; i++) send_row(i, 0, 1'b0, 1'b0);
    for (int b = 0; b <= 100; b++) begin
      in_valid = 1'b1;
      w_row_wr = 5'd10;
      POI_addr_wr = 8'(b);
      for (int l = 0; l < LANES; l++) residuals[l] = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_sad", best_sad, 0);
    begin_search();
    run_rows(4, 1'b1, 7);
    check_result("post_rst");

    // Full-range random rows in shuffled order.
    begin_search();
    run_rows(0, 1'b1, 13);
    check_result("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
